// File: rtl/tdc_uart_arbiter.sv
// tdc_uart_arbiter: round-robin arbiter that hands one of four TDC channel words
// to a UART frame sender, with start timeout and inter-frame gap.
module tdc_uart_arbiter #(
  parameter int GAP_CYCLES    = 40,
  parameter int START_TIMEOUT = 1000
) (
  input  logic        clk_20m,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [63:0] ch_data,
  output logic [3:0]  ack,
  output logic [15:0] frm_data,
  output logic        frm_valid,
  input  logic        frm_busy,
  output logic        err_timeout,
  output logic [1:0]  last_ch,
  output logic        arb_busy
);
  localparam int CNT_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  localparam state_t POST = (GAP_CYCLES == 0) ? IDLE : GAP;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    ack_q, ack_d;
  logic [15:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [1:0]    last_q, last_d;
  logic          armed_q, armed_d;
  logic [1:0]    win;
  logic          hit;
  // search starts one past the last grant; k=4 wraps back onto last_ch itself
  always_comb begin
    win = last_q;
    hit = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!hit && req[last_q + 2'(k)]) begin
        win = last_q + 2'(k);
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    last_d  = last_q;
    armed_d = 1'b1;
    unique case (state_q)
      IDLE: if (armed_q && hit) begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
        ack_d   = 4'b0001 << win;
        data_d  = ch_data[{win, 4'b0000} +: 16];
        valid_d = 1'b1;
        last_d  = win;
      end
      WAIT_BUSY: if (frm_busy) begin
        valid_d = 1'b0;
        state_d = WAIT_DONE;
      end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
        valid_d = 1'b0;
        err_d   = 1'b1;
        state_d = POST;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      WAIT_DONE: if (!frm_busy) begin
        state_d = POST;
        cnt_d   = '0;
      end
      GAP: if (cnt_q == CW'(GAP_CYCLES - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // armed_q holds off grants on the first edge after reset release
  always_ff @(posedge clk_20m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 2'd3;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      last_q  <= last_d;
      armed_q <= armed_d;
    end
  end
  assign ack         = ack_q;
  assign frm_data    = data_q;
  assign frm_valid   = valid_q;
  assign err_timeout = err_q;
  assign last_ch     = last_q;
  assign arb_busy    = (state_q != IDLE);
endmodule

// File: tb/tb_tdc_uart_arbiter.sv
// tb_tdc_uart_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_tdc_uart_arbiter;
  localparam int GAP_A = 5, TO_A = 20, GAP_B = 0, TO_B = 20;

  typedef struct packed {
    logic [1:0]  phase;
    logic [15:0] left;
    logic [1:0]  last;
    logic [15:0] data;
    logic        valid;
    logic [3:0]  ack;
    logic        err;
    logic        armed;
  } m_t;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0;
  logic [63:0] data_a = '0, data_b = '0;
  logic busy_a = 1'b0, busy_b = 1'b0;
  logic [3:0] ack_a, ack_b;
  logic [15:0] frm_data_a, frm_data_b;
  logic frm_valid_a, frm_valid_b, err_a, err_b, arb_busy_a, arb_busy_b;
  logic [1:0] last_ch_a, last_ch_b;

  int n_vec = 0, n_bad = 0;
  m_t ma, mb;
  bit cmp_on = 0, auto_a = 0, rec = 0;
  int order[$];
  int s_wait = 0, s_len = 0;
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  tdc_uart_arbiter #(.GAP_CYCLES(GAP_A), .START_TIMEOUT(TO_A)) dut_a (
    .clk_20m(clk), .reset_n(reset_n), .req(req_a), .ch_data(data_a), .ack(ack_a),
    .frm_data(frm_data_a), .frm_valid(frm_valid_a), .frm_busy(busy_a),
    .err_timeout(err_a), .last_ch(last_ch_a), .arb_busy(arb_busy_a));

  tdc_uart_arbiter #(.GAP_CYCLES(GAP_B), .START_TIMEOUT(TO_B)) dut_b (
    .clk_20m(clk), .reset_n(reset_n), .req(req_b), .ch_data(data_b), .ack(ack_b),
    .frm_data(frm_data_b), .frm_valid(frm_valid_b), .frm_busy(busy_b),
    .err_timeout(err_b), .last_ch(last_ch_b), .arb_busy(arb_busy_b));

  always #5 clk = ~clk;

  function automatic m_t m_rst();
    m_t n;
    n = '0;
    n.last = 2'd3;
    return n;
  endfunction

  // phase: 0 idle, 1 awaiting busy, 2 sending, 3 gap; left counts down remaining cycles
  function automatic m_t step(input m_t m, input logic [3:0] r, input logic [63:0] d,
                              input logic b, input int gap, input int to);
    m_t n;
    bit found;
    n = m;
    n.ack = '0;
    n.err = 1'b0;
    n.armed = 1'b1;
    found = 0;
    case (m.phase)
      2'd0: if (m.armed) for (int k = 1; k <= 4; k++) begin
        int w;
        w = (int'(m.last) + k) % 4;
        if (!found && r[w]) begin
          found = 1;
          n.last = 2'(w);
          n.data = d[16*w +: 16];
          n.valid = 1'b1;
          n.ack[w] = 1'b1;
          n.phase = 2'd1;
          n.left = 16'(to);
        end
      end
      2'd1: if (b) begin
        n.valid = 1'b0;
        n.phase = 2'd2;
      end else if (m.left == 1) begin
        n.valid = 1'b0;
        n.err = 1'b1;
        n.phase = (gap == 0) ? 2'd0 : 2'd3;
        n.left = 16'(gap);
      end else n.left = m.left - 16'd1;
      2'd2: if (!b) begin
        n.phase = (gap == 0) ? 2'd0 : 2'd3;
        n.left = 16'(gap);
      end
      default: if (m.left == 1) n.phase = 2'd0; else n.left = m.left - 16'd1;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma <= m_rst();
      mb <= m_rst();
    end else begin
      ma <= step(ma, req_a, data_a, busy_a, GAP_A, TO_A);
      mb <= step(mb, req_b, data_b, busy_b, GAP_B, TO_B);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(negedge clk) if (cmp_on) begin
    chk("a_ack", ack_a, ma.ack);
    chk("a_data", frm_data_a, ma.data);
    chk("a_valid", frm_valid_a, ma.valid);
    chk("a_err", err_a, ma.err);
    chk("a_last", last_ch_a, ma.last);
    chk("a_arb_busy", arb_busy_a, ma.phase != 0);
    chk("b_ack", ack_b, mb.ack);
    chk("b_data", frm_data_b, mb.data);
    chk("b_valid", frm_valid_b, mb.valid);
    chk("b_err", err_b, mb.err);
    chk("b_last", last_ch_b, mb.last);
    chk("b_arb_busy", arb_busy_b, mb.phase != 0);
  end

  // simple frame sender: random start delay (sometimes too long, forcing a timeout), random length
  always @(negedge clk) if (auto_a) begin
    if (busy_a) begin
      if (s_len <= 1) busy_a = 1'b0; else s_len--;
    end else if (ma.valid) begin
      if (s_wait == 0) begin
        busy_a = 1'b1;
        s_len = $urandom_range(1, 8);
      end else s_wait--;
    end else s_wait = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 5);
  end

  always @(negedge clk) if (rec && ack_a != 0)
    for (int k = 0; k < 4; k++) if (ack_a[k]) order.push_back(k);

  initial begin
    int vcnt, acnt, ecnt, g, a3;
    data_a = {$urandom, $urandom};
    repeat (3) tick();
    cmp_on = 1;
    chk("rst_last", last_ch_a, 3);
    chk("rst_valid", frm_valid_a, 0);
    chk("rst_data", frm_data_a, 0);
    chk("rst_arb_busy", arb_busy_a, 0);
    // first grant only on the second edge after release
    req_a = 4'b0001;
    data_a[15:0] = 16'hA5C3;
    reset_n = 1'b1;
    tick();
    chk("first_edge_no_grant", frm_valid_a, 0);
    tick();
    chk("grant_valid", frm_valid_a, 1);
    chk("grant_ack", ack_a, 4'b0001);
    chk("grant_data", frm_data_a, 16'hA5C3);
    req_a = '0;
    vcnt = 0;
    acnt = 0;
    for (int i = 0; i < 10; i++) begin
      vcnt += int'(frm_valid_a);
      acnt += int'(ack_a != 0);
      if (i == 2) busy_a = 1'b1;
      tick();
    end
    chk("valid_3_cycles", vcnt, 3);
    chk("single_ack", acnt, 1);
    repeat (90) tick();
    busy_a = 1'b0;
    req_a = 4'b0001;
    g = 0;
    while (g < 50 && !frm_valid_a) begin
      tick();
      g++;
    end
    chk("gap_spacing", g, GAP_A + 2);
    req_a = '0;
    s_wait = 0;
    auto_a = 1;
    repeat (60) tick();
    // round robin with all requests held
    auto_a = 0;
    busy_a = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    data_a = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    req_a = 4'hF;
    order.delete();
    rec = 1;
    auto_a = 1;
    repeat (300) tick();
    rec = 0;
    req_a = '0;
    chk("rr_count", order.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      if (i < order.size()) chk($sformatf("rr_order%0d", i), order[i], rr_exp[i]);
    repeat (60) tick();
    // start timeout with busy tied low
    auto_a = 0;
    busy_a = 1'b0;
    repeat (2) tick();
    req_a = 4'b0100;
    tick();
    vcnt = 0;
    ecnt = 0;
    for (int i = 0; i < 60; i++) begin
      vcnt += int'(frm_valid_a);
      ecnt += int'(err_a);
      if (i == 0) req_a = '0;
      tick();
    end
    chk("timeout_valid_len", vcnt, TO_A);
    chk("timeout_err_once", ecnt, 1);
    chk("timeout_last", last_ch_a, 2);
    chk("timeout_idle", arb_busy_a, 0);
    // inputs ignored while sending
    req_a = 4'b0001;
    data_a[15:0] = 16'h1234;
    tick();
    req_a = '0;
    busy_a = 1'b1;
    tick();
    data_a[15:0] = 16'hBEEF;
    req_a = 4'b1000;
    tick();
    req_a = '0;
    a3 = 0;
    for (int i = 0; i < 5; i++) begin
      a3 += int'(ack_a[3]);
      tick();
    end
    chk("hold_data", frm_data_a, 16'h1234);
    chk("no_ack3", a3, 0);
    busy_a = 1'b0;
    repeat (10) tick();
    chk("ignored_req_idle", arb_busy_a, 0);
    // asynchronous reset in mid frame
    req_a = 4'b0001;
    data_a[15:0] = 16'h7777;
    tick();
    req_a = '0;
    busy_a = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", frm_valid_a, 0);
    chk("arst_ack", ack_a, 0);
    chk("arst_data", frm_data_a, 0);
    chk("arst_err", err_a, 0);
    chk("arst_last", last_ch_a, 3);
    chk("arst_arb_busy", arb_busy_a, 0);
    tick();
    busy_a = 1'b0;
    req_a = 4'b1010;
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_ack", ack_a, 4'b0010);
    chk("post_rst_last", last_ch_a, 1);
    req_a = '0;
    repeat (30) tick();
    // randomized traffic
    auto_a = 1;
    for (int i = 0; i < 3000; i++) begin
      req_a = 4'($urandom_range(0, 15));
      data_a = {$urandom, $urandom};
      reset_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset_n = 1'b1;
    req_a = '0;
    repeat (60) tick();
    // zero-gap build: IDLE on the edge busy is seen low, next grant one edge later
    req_b = 4'b0001;
    data_b[15:0] = 16'h5A5A;
    tick();
    chk("b_grant1", frm_valid_b, 1);
    busy_b = 1'b1;
    tick();
    repeat (3) tick();
    busy_b = 1'b0;
    tick();
    chk("b_idle_after_busy", arb_busy_b, 0);
    chk("b_valid_low", frm_valid_b, 0);
    tick();
    chk("b_grant2", frm_valid_b, 1);
    chk("b_grant2_ack", ack_b, 4'b0001);
    req_b = '0;
    repeat (25) tick();
    chk("b_timeout_idle", arb_busy_b, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
